hatch_pad_ctrl: RTL and testbench

Pad-ownership controller between the SoC peripherals and the GPIO pad ring. Each bidirectional pad belongs to one function at a time: GPIO, alternate function 0, alternate function 1, or parked (hi-Z). Ownership changes are queued as single commands and executed by a sequencer. The sequencer tristates the pad for a fixed turnaround window before handing it over, so two drivers never overlap and no glitch reaches the pad.

---
 rtl/hatch_pad_pkg.sv | 25 ++
 rtl/hatch_pad_mux.sv | 51 +++++
 rtl/hatch_pad_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hatch_pad_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hatch_pad_pkg.sv
// Shared types and defaults for the pad-ownership controller.
package hatch_pad_pkg;

  typedef enum logic [1:0] {
    PadFuncGpio = 2'd0,
    PadFuncAlt0 = 2'd1,
    PadFuncAlt1 = 2'd2,
    PadFuncPark = 2'd3
  } pad_func_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pad_ctrl_state_e;

  localparam int DefaultGpioCount  = 32;
  localparam int DefaultTurnCycles = 4;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hatch_pad_mux.sv
// Single-pad ownership mux: routes one owner's out/oe to the pad and the pad input back to that owner only.
module hatch_pad_mux
  import hatch_pad_pkg::*;
(
  input  pad_func_e func_i,
  input  logic      force_i,
  input  logic      gpio_out_i,
  input  logic      gpio_oe_i,
  input  logic      alt0_out_i,
  input  logic      alt0_oe_i,
  input  logic      alt1_out_i,
  input  logic      alt1_oe_i,
  input  logic      pad_in_i,
  output logic      pad_out_o,
  output logic      pad_oe_o,
  output logic      gpio_in_o,
  output logic      alt0_in_o,
  output logic      alt1_in_o
);

  // A forced pad behaves exactly like a parked one.
  always_comb begin
    pad_out_o = 1'b0;
    pad_oe_o  = 1'b0;
    gpio_in_o = 1'b0;
    alt0_in_o = 1'b0;
    alt1_in_o = 1'b0;
    if (!force_i) begin
      case (func_i)
        PadFuncGpio: begin
          pad_out_o = gpio_out_i;
          pad_oe_o  = gpio_oe_i;
          gpio_in_o = pad_in_i;
        end
        PadFuncAlt0: begin
          pad_out_o = alt0_out_i;
          pad_oe_o  = alt0_oe_i;
          alt0_in_o = pad_in_i;
        end
        PadFuncAlt1: begin
          pad_out_o = alt1_out_i;
          pad_oe_o  = alt1_oe_i;
          alt1_in_o = pad_in_i;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/hatch_pad_ctrl.sv
// Pad-ownership controller: queues one ownership change at a time and tristates the
// target pad for a fixed turnaround window before handing it to its new owner.
module hatch_pad_ctrl
  import hatch_pad_pkg::*;
#(
  parameter int        GpioCount  = DefaultGpioCount,
  parameter int        TurnCycles = DefaultTurnCycles,
  parameter pad_func_e ResetFunc  = PadFuncGpio,
  localparam int       PadIdxW    = idx_width(GpioCount)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [PadIdxW-1:0]     cmd_pad_i,
  input  logic [1:0]             cmd_func_i,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [2*GpioCount-1:0] func_o,
  input  logic [GpioCount-1:0]   gpio_out_i,
  input  logic [GpioCount-1:0]   gpio_oe_i,
  output logic [GpioCount-1:0]   gpio_in_o,
  input  logic [GpioCount-1:0]   alt0_out_i,
  input  logic [GpioCount-1:0]   alt0_oe_i,
  output logic [GpioCount-1:0]   alt0_in_o,
  input  logic [GpioCount-1:0]   alt1_out_i,
  input  logic [GpioCount-1:0]   alt1_oe_i,
  output logic [GpioCount-1:0]   alt1_in_o,
  output logic [GpioCount-1:0]   pad_out_o,
  output logic [GpioCount-1:0]   pad_oe_o,
  input  logic [GpioCount-1:0]   pad_in_i
);

  localparam int              CntW    = idx_width(TurnCycles);
  localparam logic [CntW-1:0] CntLoad = CntW'(TurnCycles - 1);

  pad_ctrl_state_e      state_reg;
  logic [CntW-1:0]      cnt_reg;
  logic [PadIdxW-1:0]   pad_reg;
  pad_func_e            func_req_reg;
  logic                 err_reg;
  logic                 force_reg;
  logic                 done_reg;
  logic                 busy_reg;
  logic                 ready_reg;
  pad_func_e            func_reg [GpioCount];

  logic                 cmd_fire;
  logic                 pad_oob;
  logic                 drain_last;
  pad_func_e            cur_func;

  assign cmd_fire   = cmd_valid_i && ready_reg;
  assign pad_oob    = (32'(cmd_pad_i) >= 32'(GpioCount));
  assign drain_last = (state_reg == DRAIN) && (cnt_reg == '0);

  // Explicit compare-select keeps non-existent pad indices from reaching the array.
  always_comb begin
    cur_func = ResetFunc;
    for (int i = 0; i < GpioCount; i++) begin
      if (cmd_pad_i == PadIdxW'(i)) cur_func = func_reg[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pad_reg      <= '0;
      func_req_reg <= ResetFunc;
      err_reg      <= 1'b0;
      force_reg    <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            pad_reg      <= cmd_pad_i;
            func_req_reg <= pad_func_e'(cmd_func_i);
            err_reg      <= pad_oob;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            if (pad_oob || (pad_func_e'(cmd_func_i) == cur_func)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= DRAIN;
              cnt_reg   <= CntLoad;
              force_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_reg == '0) begin
            force_reg <= 1'b0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          force_reg <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // The owner changes on the same edge the force drops, so DONE already sees the new driver.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < GpioCount; i++) func_reg[i] <= ResetFunc;
    end else if (drain_last) begin
      for (int i = 0; i < GpioCount; i++) begin
        if (pad_reg == PadIdxW'(i)) func_reg[i] <= func_req_reg;
      end
    end
  end

  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign busy_o      = busy_reg;
  assign cmd_ready_o = ready_reg;

  for (genvar gi = 0; gi < GpioCount; gi++) begin : g_pad
    logic force_pad;
    assign force_pad           = force_reg && (pad_reg == PadIdxW'(gi));
    assign func_o[2*gi +: 2]   = func_reg[gi];

    hatch_pad_mux u_mux (
      .func_i     (func_reg[gi]),
      .force_i    (force_pad),
      .gpio_out_i (gpio_out_i[gi]),
      .gpio_oe_i  (gpio_oe_i[gi]),
      .alt0_out_i (alt0_out_i[gi]),
      .alt0_oe_i  (alt0_oe_i[gi]),
      .alt1_out_i (alt1_out_i[gi]),
      .alt1_oe_i  (alt1_oe_i[gi]),
      .pad_in_i   (pad_in_i[gi]),
      .pad_out_o  (pad_out_o[gi]),
      .pad_oe_o   (pad_oe_o[gi]),
      .gpio_in_o  (gpio_in_o[gi]),
      .alt0_in_o  (alt0_in_o[gi]),
      .alt1_in_o  (alt1_in_o[gi])
    );
  end

endmodule

// File: tb/tb_hatch_pad_ctrl.sv
// Directed bench for hatch_pad_ctrl: table of ownership commands with hand-computed
// latency and pad routing, plus sequences for held valid and reset during drain.
module tb_hatch_pad_ctrl;

  localparam int N  = 20;
  localparam int TC = 4;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [4:0]      cmd_pad = '0;
  logic [1:0]      cmd_func = '0;
  logic            done, err, busy;
  logic [2*N-1:0]  func_o;
  logic [N-1:0]    gpio_out, gpio_oe, gpio_in;
  logic [N-1:0]    alt0_out, alt0_oe, alt0_in;
  logic [N-1:0]    alt1_out, alt1_oe, alt1_in;
  logic [N-1:0]    pad_out, pad_oe, pad_in;

  always #5 clk = ~clk;

  hatch_pad_ctrl #(.GpioCount(N), .TurnCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_pad_i(cmd_pad), .cmd_func_i(cmd_func),
    .done_o(done), .err_o(err), .busy_o(busy), .func_o(func_o),
    .gpio_out_i(gpio_out), .gpio_oe_i(gpio_oe), .gpio_in_o(gpio_in),
    .alt0_out_i(alt0_out), .alt0_oe_i(alt0_oe), .alt0_in_o(alt0_in),
    .alt1_out_i(alt1_out), .alt1_oe_i(alt1_oe), .alt1_in_o(alt1_in),
    .pad_out_o(pad_out), .pad_oe_o(pad_oe), .pad_in_i(pad_in)
  );

  typedef struct {
    int         pad;
    logic [1:0] func;
    logic gout, goe, a0out, a0oe, a1out, a1oe, pin;
    int         lat;
    logic       err;
    logic pout, poe, gin, a0in, a1in;
  } vec_t;

  vec_t       vecs [10];
  logic [1:0] exp_func [N];
  int         n_vec = 0;
  int         n_bad = 0;
  int         done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] pack_model();
    logic [2*N-1:0] r;
    for (int i = 0; i < N; i++) r[2*i +: 2] = exp_func[i];
    return r;
  endfunction

  // Issue one command at a negedge, then count periods until done_o.
  task automatic run_cmd(input int pad, input logic [1:0] func, input int exp_lat, input logic exp_err);
    int lat;
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_pad   = pad[4:0];
    cmd_func  = func;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_pad   = ~cmd_pad;
    cmd_func  = ~cmd_func;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      lat = c;
      if (done) break;
      if (pad < N)
        check("drain_force", {59'd0, pad_oe[pad], pad_out[pad], gpio_in[pad], alt0_in[pad], alt1_in[pad]}, 64'd0);
      check("drain_neighbours", {60'd0, pad_oe[4], pad_out[4], pad_oe[6], pad_out[6]},
            {60'd0, gpio_oe[4], gpio_out[4], gpio_oe[6], gpio_out[6]});
    end
    if (!exp_err && pad < N) exp_func[pad] = func;
    $display("txn pad=%0d func=%0d latency=%0d done=%0b err=%0b func_o=%0h", pad, func, lat, done, err, func_o);
    check("latency", 64'(lat), 64'(exp_lat));
    check("done_err", {62'd0, done, err}, {62'd0, 1'b1, exp_err});
    check("func_o", 64'(func_o), 64'(pack_model()));
  endtask

  initial begin
    vecs[0] = '{5,  2'd0, 1,1,0,0,0,0,1, 1, 1'b0, 1,1,1,0,0};
    vecs[1] = '{5,  2'd1, 0,1,1,1,0,0,1, 5, 1'b0, 1,1,0,1,0};
    vecs[2] = '{5,  2'd1, 1,1,0,1,0,0,0, 1, 1'b0, 0,1,0,0,0};
    vecs[3] = '{25, 2'd2, 0,0,0,0,0,0,0, 1, 1'b1, 0,0,0,0,0};
    vecs[4] = '{0,  2'd3, 1,1,1,1,1,1,1, 5, 1'b0, 0,0,0,0,0};
    vecs[5] = '{12, 2'd2, 1,1,0,0,1,0,1, 5, 1'b0, 1,0,0,0,1};
    vecs[6] = '{0,  2'd0, 1,0,0,0,0,0,1, 5, 1'b0, 1,0,1,0,0};
    vecs[7] = '{19, 2'd1, 0,1,1,1,0,0,0, 5, 1'b0, 1,1,0,0,0};
    vecs[8] = '{20, 2'd0, 0,0,0,0,0,0,0, 1, 1'b1, 0,0,0,0,0};
    vecs[9] = '{31, 2'd3, 0,0,0,0,0,0,0, 1, 1'b1, 0,0,0,0,0};

    for (int i = 0; i < N; i++) exp_func[i] = 2'd0;
    gpio_out = 20'hA5C3B;
    gpio_oe  = '1;
    alt0_out = '0; alt0_oe = '0;
    alt1_out = '0; alt1_oe = '0;
    pad_in   = '0;

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset_ctrl", {60'd0, cmd_ready, busy, done, err}, {60'd0, 4'b1000});
    check("reset_func_o", 64'(func_o), 64'd0);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].pad < N) begin
        gpio_out[vecs[v].pad] = vecs[v].gout;
        gpio_oe[vecs[v].pad]  = vecs[v].goe;
        alt0_out[vecs[v].pad] = vecs[v].a0out;
        alt0_oe[vecs[v].pad]  = vecs[v].a0oe;
        alt1_out[vecs[v].pad] = vecs[v].a1out;
        alt1_oe[vecs[v].pad]  = vecs[v].a1oe;
        pad_in[vecs[v].pad]   = vecs[v].pin;
      end
      run_cmd(vecs[v].pad, vecs[v].func, vecs[v].lat, vecs[v].err);
      if (vecs[v].pad < N) begin
        check("mux_pad_out", 64'(pad_out[vecs[v].pad]), 64'(vecs[v].pout));
        check("mux_pad_oe",  64'(pad_oe[vecs[v].pad]),  64'(vecs[v].poe));
        check("mux_in_route",
              {61'd0, gpio_in[vecs[v].pad], alt0_in[vecs[v].pad], alt1_in[vecs[v].pad]},
              {61'd0, vecs[v].gin, vecs[v].a0in, vecs[v].a1in});
      end
    end

    // Held valid on a no-op: accepted every other cycle, never while in DONE.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pad   = 5'd5;
    cmd_func  = 2'd1;
    for (int k = 0; k < 6; k++) begin
      check("held_valid", {62'd0, done, cmd_ready}, {62'd0, (k % 2 == 1), (k % 2 == 0)});
      $display("txn held_valid cycle=%0d done=%0b ready=%0b", k, done, cmd_ready);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the second drain cycle of a switch on pad 12.
    begin
      int snap;
      alt1_oe[12]  = 1'b1;
      alt1_out[12] = 1'b1;
      cmd_valid = 1'b1;
      cmd_pad   = 5'd12;
      cmd_func  = 2'd0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      snap = done_cnt;
      @(negedge clk);
      @(negedge clk);
      check("rst_drain_force", {62'd0, pad_oe[12], busy}, {62'd0, 1'b0, 1'b1});
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_async_ctrl", {60'd0, cmd_ready, busy, done, err}, {60'd0, 4'b1000});
      check("rst_async_func_o", 64'(func_o), 64'd0);
      check("rst_pad_owner", {62'd0, pad_oe[12], pad_out[12]}, {62'd0, gpio_oe[12], gpio_out[12]});
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < N; i++) exp_func[i] = 2'd0;
      $display("txn reset_mid_drain done_pulses=%0d ready=%0b", done_cnt - snap, cmd_ready);
      check("rst_no_done", 64'(done_cnt - snap), 64'd0);
      check("rst_ready_after", {62'd0, cmd_ready, busy}, {62'd0, 2'b10});
    end

    run_cmd(3, 2'd2, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
